// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO behind the Uart8 receiver, with overflow and error-drop reporting.
// Define UART_RX_FIFO_ERR_TAG_EN to store rxErr alongside each byte instead of dropping errored bytes.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxDone,
  input  logic                rxErr,
  input  logic [7:0]          rxByte,
  output logic                outValid,
  input  logic                outReady,
  output logic [7:0]          outByte,
  output logic                outErr,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  input  logic                clearOverflow,
  output logic [7:0]          dropCount
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int unsigned ENTRY_W = 9;
`else
  localparam int unsigned ENTRY_W = 8;
`endif
  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic                  donePrev;
  logic                  push;
  logic                  pop;
  logic                  pushData;
  logic                  pushDrop;
  logic                  accept;
  logic                  setOverflow;
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [ENTRY_W-1:0]    wrEntry;
  logic [ENTRY_W-1:0]    rdEntry;
  logic [ENTRY_W-1:0]    mem [DEPTH];

  // Push/pop decode; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    push        = rxDone & ~donePrev;
    empty       = (count == '0);
    full        = (count == FULL_COUNT);
    outValid    = ~empty;
    pop         = outValid & outReady;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    pushData    = push;
    pushDrop    = 1'b0;
    wrEntry     = {rxErr, rxByte};
`else
    pushData    = push & ~rxErr;
    pushDrop    = push & rxErr;
    wrEntry     = rxByte;
`endif
    accept      = pushData & (~full | pop);
    setOverflow = pushData & full & ~pop;
  end

  always_comb begin
    rdEntry = mem[rdPtr];
`ifdef UART_RX_FIFO_ERR_TAG_EN
    outByte = rdEntry[7:0];
    outErr  = rdEntry[8];
`else
    outByte = rdEntry;
    outErr  = 1'b0;
`endif
  end

  // Storage is not reset; entries are unobservable until rewritten.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      mem[wrPtr] <= wrEntry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      donePrev  <= 1'b1;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      dropCount <= '0;
    end else begin
      donePrev <= rxDone;
      if (accept) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      count <= count + CNT_W'(accept) - CNT_W'(pop);
      // Set wins over a same-cycle clear.
      if (setOverflow) begin
        overflow <= 1'b1;
      end else if (clearOverflow) begin
        overflow <= 1'b0;
      end
      if (pushDrop && (dropCount != 8'hFF)) begin
        dropCount <= dropCount + 8'd1;
      end
    end
  end

endmodule
